// File: rtl/soc_mem_pkg.sv
// -----------------------------------------------------------------------------
// soc_mem_pkg
//   Shared definitions for the on-chip RAM arbiter.
//   - Default geometry of the 1024x32 RAM (word address, data, byte enables).
//   - RAM read latency in cycles (depth of the read-tag pipeline).
//   - Lock FSM state encoding and the grant mask each state allows.
// -----------------------------------------------------------------------------
package soc_mem_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_BE_W   = DEF_DATA_W / 8;
   localparam int RD_LATENCY = 1;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      OWN0     = 2'd1,
      OWN1     = 2'd2
   } lock_state_e;

   // Masters allowed to win arbitration in a given lock state.
   function automatic logic [1:0] lock_mask(input lock_state_e st);
      logic [1:0] m;
      case (st)
         OWN0:    m = 2'b01;
         OWN1:    m = 2'b10;
         default: m = 2'b11;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/soc_memory_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
//   Combinational two-way round-robin pick.
//   Ports:
//     req        in  [1:0]  raw requests (bit N = master N)
//     last_grant in  1      index of the master that issued last
//     mask       in  [1:0]  masters eligible this cycle (lock / reset_req gating)
//     grant      out [1:0]  one-hot grant, or 0 when nobody is eligible
// -----------------------------------------------------------------------------
module rr_arbiter2
   import soc_mem_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic [1:0] mask,
   output logic [1:0] grant
);

   logic [1:0] elig;

   always_comb begin
      elig  = req & mask;
      grant = elig;
      // Tie: the master that did not issue last goes first.
      if (&elig)
         grant = last_grant ? 2'b01 : 2'b10;
   end

endmodule

// File: rtl/soc_memory_arbiter.sv
// -----------------------------------------------------------------------------
// soc_memory_arbiter
//   Shares the single-port on-chip RAM between two Avalon-MM masters
//   (m0 = Nios II data master, m1 = alarm/timekeeping engine). One beat per
//   cycle, granted combinationally in the request cycle, round-robin on ties,
//   with a lock that lets one master keep the RAM across a read-modify-write.
//   Read data returns one cycle after issue and is steered by a one-hot tag.
//   Ports:
//     clk, reset            clock, async active-high reset
//     reset_req             blocks new grants, forwarded to the RAM
//     mN_*                  Avalon-MM slave side for master N (N = 0, 1)
//     mem_*                 Avalon-MM master side towards the RAM
// -----------------------------------------------------------------------------
module soc_memory_arbiter
   import soc_mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int BE_W   = DEF_BE_W
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              reset_req,

   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   input  logic              m0_lock,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,

   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   input  logic              m1_lock,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,

   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   output logic              mem_reset_req,
   input  logic [DATA_W-1:0] mem_readdata
);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [BE_W-1:0]   be;
      logic              rd;
      logic              wr;
      logic [DATA_W-1:0] wdata;
      logic              lock;
   } mreq_t;

   mreq_t [1:0] mreq;
   logic  [1:0] req;
   logic  [1:0] own_mask;
   logic  [1:0] grant;
   logic        issue;
   logic        sel;

   lock_state_e state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic [1:0]  rd_tag_d;
   logic [RD_LATENCY-1:0][1:0] rd_tag_q;

   assign mreq[0] = '{addr: m0_address, be: m0_byteenable, rd: m0_read,
                      wr: m0_write, wdata: m0_writedata, lock: m0_lock};
   assign mreq[1] = '{addr: m1_address, be: m1_byteenable, rd: m1_read,
                      wr: m1_write, wdata: m1_writedata, lock: m1_lock};

   assign req = {mreq[1].rd | mreq[1].wr, mreq[0].rd | mreq[0].wr};

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= UNLOCKED;
         last_grant_q <= 1'b1;          // m0 wins the first tie
         rd_tag_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         rd_tag_q[0]  <= rd_tag_d;
         for (int i = 1; i < RD_LATENCY; i++)
            rd_tag_q[i] <= rd_tag_q[i-1];
      end
   end

   // ------------------------------------------------------ lock next state
   // Only a granted beat moves the FSM; with the owner idle it simply holds.
   always_comb begin
      state_d = state_q;
      if (issue)
         state_d = mreq[sel].lock ? (sel ? OWN1 : OWN0) : UNLOCKED;
   end

   // --------------------------------------------------- lock FSM outputs
   // Nobody is eligible while in reset or while a reset is being requested.
   always_comb begin
      own_mask = lock_mask(state_q);
      if (reset || reset_req)
         own_mask = 2'b00;
   end

   rr_arbiter2 u_rr (
      .req        (req),
      .last_grant (last_grant_q),
      .mask       (own_mask),
      .grant      (grant)
   );

   assign issue        = |grant;
   assign sel          = grant[1];     // idle selects master 0
   assign last_grant_d = issue ? sel : last_grant_q;

   // --------------------------------------------------------- issue mux
   // Write wins when a master raises read and write together.
   always_comb begin
      mem_address    = mreq[sel].addr;
      mem_write      = mreq[sel].wr;
      mem_writedata  = mreq[sel].wdata;
      mem_byteenable = mreq[sel].wr ? mreq[sel].be : {BE_W{1'b1}};
      mem_chipselect = issue;
      rd_tag_d       = 2'b00;
      if (issue && !mreq[sel].wr)
         rd_tag_d = sel ? 2'b10 : 2'b01;
   end

   assign mem_clken     = 1'b1;
   assign mem_reset_req = reset_req;

   // ------------------------------------------------------- master side
   assign m0_waitrequest   = req[0] & ~grant[0];
   assign m1_waitrequest   = req[1] & ~grant[1];
   assign m0_readdatavalid = rd_tag_q[RD_LATENCY-1][0];
   assign m1_readdatavalid = rd_tag_q[RD_LATENCY-1][1];
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;

endmodule
